hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core (fetch, decode, execute, memory, writeback). It sits beside the decode and execute stages. It generates per-stage stall and flush strobes, selects execute-stage operand forwarding, and holds the pipeline while the data memory handshake is outstanding. It also drains and halts the core when a finish instruction (SYSTEM or illegal opcode) reaches execute, and keeps free-running cycle, stall and flush counters for the simulation harness.

## Interface
Parameters:
- WORD, 32, data/counter width
- REG_SIZE, 5, register address width

Ports:
- clk  in  1  pipeline clock, all state on posedge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- raddr1D, raddr2D  in  REG_SIZE  source registers of instruction in decode
- raddr1E, raddr2E  in  REG_SIZE  source registers of instruction in execute
- writeRegE  in  REG_SIZE; regWriteE, mem2regE, validE  in  1  execute-stage destination/controls
- branchTakenE  in  1  taken branch, JAL or JALR resolved in execute
- finishE  in  1  finish flag of instruction in execute
- writeRegM  in  REG_SIZE; regWriteM  in  1  memory-stage destination
- writeRegW  in  REG_SIZE; regWriteW  in  1  writeback-stage destination
- memReqM, memAckM  in  1  data memory request/acknowledge for memory stage
- stallF, stallD, stallE, stallM  out  1  hold stage register
- flushD, flushE  out  1  load bubble (valid=0) into stage register
- fwd1E, fwd2E  out  2  operand select: 00 regfile, 01 writeback result, 10 memory-stage ALU result
- halted  out  1  core halted
- cycleCnt, stallCnt, flushCnt  out  WORD  performance counters

## Operation
- Forwarding, shown for fwd1E (fwd2E identical with raddr2E):
  - 10 if regWriteM && writeRegM!=0 && writeRegM==raddr1E
  - else 01 if regWriteW && writeRegW!=0 && writeRegW==raddr1E
  - else 00
  - Memory stage has priority.
- memStall = memReqM && !memAckM.
- lwStall = validE && mem2regE && regWriteE && writeRegE!=0 && (writeRegE==raddr1D || writeRegE==raddr2D).
- No decode/writeback hazard: the regfile writes on negedge.
- redirect = validE && branchTakenE.
- Strobe priority in RUN, highest first:
  - memStall: stallF=stallD=stallE=stallM=1, no flush. Redirect and finish wait.
  - redirect: flushD=flushE=1. lwStall is ignored because the instruction in decode is wrong-path.
  - lwStall: stallF=stallD=1, flushE=1.
  - otherwise all strobes 0.
- FSM states: RUN, DRAIN, HALTED.
  - RUN→DRAIN: validE && finishE && !memStall. Load 2-bit drainCnt=2. redirect is not taken on that cycle.
  - DRAIN:
    - stallF=stallD=1 and flushE=1 every cycle.
    - memStall additionally asserts stallM and freezes drainCnt.
    - Otherwise drainCnt decrements. On the cycle it reaches 0 the state goes to HALTED.
  - HALTED: all four stalls=1, flushes=0, halted=1. Leaves only via reset.
- Counters:
  - cycleCnt +1 every cycle in RUN or DRAIN.
  - stallCnt +1 each RUN cycle where memStall or (lwStall && !redirect).
  - flushCnt +1 each RUN cycle where redirect && !memStall.
  - All wrap modulo 2^WORD. All frozen in HALTED.

## Timing
- Reset (reset=0, asynchronous): state=RUN, drainCnt=0, halted=0, all counters 0. Strobes then follow inputs combinationally.
- Stall, flush and forward outputs are combinational, valid in the same cycle as their inputs. halted and counters are registered.
- Load-use costs exactly one bubble:
  - Cycle n: lw in execute, consumer in decode, so stall.
  - Cycle n+1: validE=0, so no stall.
  - Cycle n+2: consumer in execute with fwd=01.
- halted rises 3 clock edges after the finish instruction is in execute, when there is no memStall. Each memStall cycle in DRAIN adds one cycle.
- Reset asserted mid-DRAIN aborts to RUN with counters cleared. No partial halt.
- Register x0 never forwards or stalls.

## Test plan
- Forwarding: writeRegM=5, regWriteM=1 and writeRegW=5, regWriteW=1, raddr1E=5 -> fwd1E=10. Drop regWriteM -> fwd1E=01. raddr1E=0 -> 00.
- Load-use: validE=1, mem2regE=1, regWriteE=1, writeRegE=7, raddr2D=7 -> stallF=stallD=flushE=1 for one cycle, stallCnt 0→1. Next cycle validE=0 -> strobes 0.
- Redirect over load-use: branchTakenE=1 with the lwStall conditions true -> flushD=flushE=1, stallF=0, flushCnt=1, stallCnt=0.
- Memory wait: memReqM=1, memAckM=0 for 3 cycles with redirect=1 -> all stalls=1, no flush, stallCnt=3. On ack -> flushD=flushE=1.
- Halt: finishE=validE=1 at cycle 10 -> DRAIN cycles 11-12, halted=1 from cycle 13. cycleCnt frozen at 13, all stalls=1 thereafter.
- Reset mid-drain and wrap: reset=0 during DRAIN -> halted=0, counters 0 immediately. With WORD=4, 16 RUN cycles -> cycleCnt wraps to 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage core: stall/flush strobes,
// execute-stage operand forwarding, finish-instruction drain/halt and performance counters.
module hazard_ctrl #(
    parameter int WORD     = 32,
    parameter int REG_SIZE = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_SIZE-1:0] raddr1D,
    input  logic [REG_SIZE-1:0] raddr2D,
    input  logic [REG_SIZE-1:0] raddr1E,
    input  logic [REG_SIZE-1:0] raddr2E,
    input  logic [REG_SIZE-1:0] writeRegE,
    input  logic                regWriteE,
    input  logic                mem2regE,
    input  logic                validE,
    input  logic                branchTakenE,
    input  logic                finishE,
    input  logic [REG_SIZE-1:0] writeRegM,
    input  logic                regWriteM,
    input  logic [REG_SIZE-1:0] writeRegW,
    input  logic                regWriteW,
    input  logic                memReqM,
    input  logic                memAckM,
    output logic                stallF,
    output logic                stallD,
    output logic                stallE,
    output logic                stallM,
    output logic                flushD,
    output logic                flushE,
    output logic [1:0]          fwd1E,
    output logic [1:0]          fwd2E,
    output logic                halted,
    output logic [WORD-1:0]     cycleCnt,
    output logic [WORD-1:0]     stallCnt,
    output logic [WORD-1:0]     flushCnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'b00,
        S_DRAIN  = 2'b01,
        S_HALTED = 2'b10
    } state_t;

    localparam logic [WORD-1:0] CNT_ONE = {{(WORD-1){1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [1:0]      drain_cnt_q, drain_cnt_d;
    logic            halted_q, halted_d;
    logic [WORD-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [WORD-1:0] stall_cnt_q, stall_cnt_d;
    logic [WORD-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_stall;
    logic lw_stall;
    logic redirect;
    logic finish_go;

    // Forwarding: both execute operands share the same priority mux.
    logic [1:0][REG_SIZE-1:0] raddr_e;
    logic [1:0][1:0]          fwd_sel;

    assign raddr_e = {raddr2E, raddr1E};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_m;
            logic hit_w;
            assign hit_m = regWriteM && (writeRegM != '0) && (writeRegM == raddr_e[gi]);
            assign hit_w = regWriteW && (writeRegW != '0) && (writeRegW == raddr_e[gi]);
            assign fwd_sel[gi] = hit_m ? 2'b10 : (hit_w ? 2'b01 : 2'b00);
        end
    endgenerate

    assign fwd1E = fwd_sel[0];
    assign fwd2E = fwd_sel[1];

    assign mem_stall = memReqM && !memAckM;
    assign lw_stall  = validE && mem2regE && regWriteE && (writeRegE != '0) &&
                       ((writeRegE == raddr1D) || (writeRegE == raddr2D));
    assign redirect  = validE && branchTakenE;
    assign finish_go = validE && finishE && !mem_stall;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;

        case (state_q)
            S_RUN: begin
                cycle_cnt_d = cycle_cnt_q + CNT_ONE;
                if (mem_stall || (lw_stall && !redirect)) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
                if (redirect && !mem_stall && !finish_go) begin
                    flush_cnt_d = flush_cnt_q + CNT_ONE;
                end

                if (mem_stall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    stallE = 1'b1;
                    stallM = 1'b1;
                end else if (finish_go) begin
                    // Younger instructions must not follow the finish into execute.
                    stallF      = 1'b1;
                    stallD      = 1'b1;
                    flushE      = 1'b1;
                    state_d     = S_DRAIN;
                    drain_cnt_d = 2'd2;
                end else if (redirect) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (lw_stall) begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                end
            end

            S_DRAIN: begin
                cycle_cnt_d = cycle_cnt_q + CNT_ONE;
                stallF      = 1'b1;
                stallD      = 1'b1;
                flushE      = 1'b1;
                if (mem_stall) begin
                    stallM = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - 2'd1;
                    if (drain_cnt_q == 2'd1) begin
                        state_d = S_HALTED;
                    end
                end
            end

            S_HALTED: begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
            end

            default: begin
                state_d     = S_RUN;
                drain_cnt_d = 2'd0;
            end
        endcase

        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            drain_cnt_q <= 2'd0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign halted   = halted_q;
    assign cycleCnt = cycle_cnt_q;
    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model-predicted outputs per cycle,
// a negedge monitor pops and compares them against the DUT (plus a WORD=4 wrap instance).
module tb_hazard_ctrl;

    typedef struct {
        logic       rst_n;
        logic [4:0] r1d, r2d, r1e, r2e, we;
        logic       rwe, m2r, ve, bt, fin;
        logic [4:0] wm;
        logic       rwm;
        logic [4:0] ww;
        logic       rww;
        logic       mreq, mack;
    } stim_t;

    typedef struct {
        logic        st_f, st_d, st_e, st_m, fl_d, fl_e;
        logic [1:0]  f1, f2;
        logic        hlt;
        logic [31:0] cyc, stc, flc;
        logic [3:0]  cyc4;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic [4:0] raddr1D = '0, raddr2D = '0, raddr1E = '0, raddr2E = '0, writeRegE = '0;
    logic       regWriteE = 1'b0, mem2regE = 1'b0, validE = 1'b0, branchTakenE = 1'b0, finishE = 1'b0;
    logic [4:0] writeRegM = '0, writeRegW = '0;
    logic       regWriteM = 1'b0, regWriteW = 1'b0, memReqM = 1'b0, memAckM = 1'b0;

    logic        stallF, stallD, stallE, stallM, flushD, flushE, halted;
    logic [1:0]  fwd1E, fwd2E;
    logic [31:0] cycleCnt, stallCnt, flushCnt;

    logic        s4F, s4D, s4E, s4M, f4D, f4E, halted4;
    logic [1:0]  fw4a, fw4b;
    logic [3:0]  cyc4, stc4, flc4;

    hazard_ctrl u_dut (
        .clk(clk), .reset(reset),
        .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .mem2regE(mem2regE), .validE(validE),
        .branchTakenE(branchTakenE), .finishE(finishE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .writeRegW(writeRegW), .regWriteW(regWriteW),
        .memReqM(memReqM), .memAckM(memAckM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .fwd1E(fwd1E), .fwd2E(fwd2E),
        .halted(halted), .cycleCnt(cycleCnt), .stallCnt(stallCnt), .flushCnt(flushCnt)
    );

    hazard_ctrl #(.WORD(4), .REG_SIZE(5)) u_dut4 (
        .clk(clk), .reset(reset),
        .raddr1D(raddr1D), .raddr2D(raddr2D), .raddr1E(raddr1E), .raddr2E(raddr2E),
        .writeRegE(writeRegE), .regWriteE(regWriteE), .mem2regE(mem2regE), .validE(validE),
        .branchTakenE(branchTakenE), .finishE(finishE),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .writeRegW(writeRegW), .regWriteW(regWriteW),
        .memReqM(memReqM), .memAckM(memAckM),
        .stallF(s4F), .stallD(s4D), .stallE(s4E), .stallM(s4M),
        .flushD(f4D), .flushE(f4E), .fwd1E(fw4a), .fwd2E(fw4b),
        .halted(halted4), .cycleCnt(cyc4), .stallCnt(stc4), .flushCnt(flc4)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference model: pipeline mode 0=running, 1=draining, 2=halted.
    int          m_mode  = 0;
    int          m_left  = 0;
    int unsigned m_cyc   = 0;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;

    function automatic logic [1:0] model_fwd(input stim_t s, input logic [4:0] ra);
        if (s.rwm && s.wm != 0 && s.wm == ra) return 2'b10;
        if (s.rww && s.ww != 0 && s.ww == ra) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s txn=%0d actual=%0d required=%0d", name, txn, act, req);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        logic ms, lw, rd, fg;
        @(posedge clk);
        #1;
        reset = s.rst_n;
        raddr1D = s.r1d; raddr2D = s.r2d; raddr1E = s.r1e; raddr2E = s.r2e;
        writeRegE = s.we; regWriteE = s.rwe; mem2regE = s.m2r; validE = s.ve;
        branchTakenE = s.bt; finishE = s.fin;
        writeRegM = s.wm; regWriteM = s.rwm; writeRegW = s.ww; regWriteW = s.rww;
        memReqM = s.mreq; memAckM = s.mack;

        ms = s.mreq && !s.mack;
        lw = s.ve && s.m2r && s.rwe && s.we != 0 && (s.we == s.r1d || s.we == s.r2d);
        rd = s.ve && s.bt;
        fg = s.ve && s.fin && !ms;
        if (!s.rst_n) begin
            m_mode = 0; m_left = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
        end

        e.st_f = 0; e.st_d = 0; e.st_e = 0; e.st_m = 0; e.fl_d = 0; e.fl_e = 0;
        if (m_mode == 0) begin
            if (ms) begin
                e.st_f = 1; e.st_d = 1; e.st_e = 1; e.st_m = 1;
            end else if (fg || (lw && !rd)) begin
                e.st_f = 1; e.st_d = 1; e.fl_e = 1;
            end else if (rd) begin
                e.fl_d = 1; e.fl_e = 1;
            end
        end else if (m_mode == 1) begin
            e.st_f = 1; e.st_d = 1; e.fl_e = 1; e.st_m = ms;
        end else begin
            e.st_f = 1; e.st_d = 1; e.st_e = 1; e.st_m = 1;
        end
        e.f1   = model_fwd(s, s.r1e);
        e.f2   = model_fwd(s, s.r2e);
        e.hlt  = (m_mode == 2);
        e.cyc  = m_cyc;
        e.stc  = m_stall;
        e.flc  = m_flush;
        e.cyc4 = 4'(m_cyc % 16);
        exp_q.push_back(e);

        if (s.rst_n) begin
            if (m_mode == 0) begin
                m_cyc++;
                if (ms || (lw && !rd)) m_stall++;
                if (rd && !ms && !fg) m_flush++;
                if (fg) begin
                    m_mode = 1; m_left = 2;
                end
            end else if (m_mode == 1) begin
                m_cyc++;
                if (!ms) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stallF", 32'(stallF), 32'(e.st_f));
                check("stallD", 32'(stallD), 32'(e.st_d));
                check("stallE", 32'(stallE), 32'(e.st_e));
                check("stallM", 32'(stallM), 32'(e.st_m));
                check("flushD", 32'(flushD), 32'(e.fl_d));
                check("flushE", 32'(flushE), 32'(e.fl_e));
                check("fwd1E", 32'(fwd1E), 32'(e.f1));
                check("fwd2E", 32'(fwd2E), 32'(e.f2));
                check("halted", 32'(halted), 32'(e.hlt));
                check("cycleCnt", cycleCnt, e.cyc);
                check("stallCnt", stallCnt, e.stc);
                check("flushCnt", flushCnt, e.flc);
                check("cycleCnt4", 32'(cyc4), 32'(e.cyc4));
                $display("txn %0d st=%b%b%b%b fl=%b%b fwd=%b/%b halted=%b cyc=%0d stall=%0d flush=%0d cyc4=%0d",
                         txn, stallF, stallD, stallE, stallM, flushD, flushE, fwd1E, fwd2E,
                         halted, cycleCnt, stallCnt, flushCnt, cyc4);
                txn++;
            end
        end
    end

    initial begin : driver
        stim_t idle, s;
        idle = '{rst_n: 1'b1, r1d: 5'd0, r2d: 5'd0, r1e: 5'd0, r2e: 5'd0, we: 5'd0,
                 rwe: 1'b0, m2r: 1'b0, ve: 1'b0, bt: 1'b0, fin: 1'b0,
                 wm: 5'd0, rwm: 1'b0, ww: 5'd0, rww: 1'b0, mreq: 1'b0, mack: 1'b0};

        s = idle; s.rst_n = 1'b0;
        step(s); step(s);

        // Forwarding priority and x0.
        s = idle; s.wm = 5; s.rwm = 1; s.ww = 5; s.rww = 1; s.r1e = 5; s.r2e = 5;
        step(s);
        s.rwm = 0; step(s);
        s.r1e = 0; s.wm = 0; s.rwm = 1; step(s);

        // Load-use bubble, then the bubble in execute.
        s = idle; s.ve = 1; s.m2r = 1; s.rwe = 1; s.we = 7; s.r2d = 7;
        step(s);
        s.ve = 0; step(s);

        // Redirect beats load-use.
        s = idle; s.ve = 1; s.m2r = 1; s.rwe = 1; s.we = 7; s.r2d = 7; s.bt = 1;
        step(s);

        // Memory wait holds a pending redirect.
        s = idle; s.ve = 1; s.bt = 1; s.mreq = 1; s.mack = 0;
        step(s); step(s); step(s);
        s.mack = 1; step(s);

        // Load-use on x0 never stalls.
        s = idle; s.ve = 1; s.m2r = 1; s.rwe = 1; s.we = 0; s.r1d = 0;
        step(s);

        for (int i = 0; i < 200; i++) begin
            s = idle;
            s.r1d = 5'($urandom_range(0, 7)); s.r2d = 5'($urandom_range(0, 7));
            s.r1e = 5'($urandom_range(0, 7)); s.r2e = 5'($urandom_range(0, 7));
            s.we  = 5'($urandom_range(0, 7)); s.wm  = 5'($urandom_range(0, 7));
            s.ww  = 5'($urandom_range(0, 7));
            s.rwe = 1'($urandom); s.m2r = 1'($urandom); s.ve = 1'($urandom);
            s.bt  = ($urandom_range(0, 3) == 0); s.rwm = 1'($urandom); s.rww = 1'($urandom);
            s.mreq = ($urandom_range(0, 9) < 3); s.mack = 1'($urandom);
            step(s);
        end

        // Halt: finish at cycle 10 after reset, halted from cycle 13.
        s = idle; s.rst_n = 0; step(s);
        for (int i = 0; i < 10; i++) step(idle);
        s = idle; s.ve = 1; s.fin = 1; step(s);
        for (int i = 0; i < 6; i++) step(idle);

        // Finish pending behind a memory wait, then memory waits during drain.
        s = idle; s.rst_n = 0; step(s);
        for (int i = 0; i < 3; i++) step(idle);
        s = idle; s.ve = 1; s.fin = 1; s.mreq = 1; step(s);
        s.mack = 1; step(s);
        s = idle; s.mreq = 1; step(s); step(s);
        for (int i = 0; i < 5; i++) step(idle);

        // Reset in the middle of a drain, then run long enough for the 4-bit counter to wrap.
        s = idle; s.rst_n = 0; step(s);
        step(idle); step(idle);
        s = idle; s.ve = 1; s.fin = 1; step(s);
        step(idle);
        s = idle; s.rst_n = 0; step(s);
        for (int i = 0; i < 20; i++) step(idle);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
